// File: rtl/sort_pkg.sv
// Definitions shared by the insertion-sort chain: default word width,
// one-hot FSM encodings and the signed data word type.
package sort_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  typedef logic signed [DATA_W_DEFAULT-1:0] data_t;

endpackage

// File: rtl/sort_collect_if.sv
// Bundle of the chain handshake, the input stream from the last sort cell
// and the ap_memory-style result RAM port of sort_collect.
interface sort_collect_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);

  logic                     ap_start;
  logic                     ap_done;
  logic                     ap_continue;
  logic                     ap_idle;
  logic                     ap_ready;
  logic signed [DATA_W-1:0] in_V_dout;
  logic                     in_V_empty_n;
  logic                     in_V_read;
  logic        [ADDR_W-1:0] res_address0;
  logic                     res_ce0;
  logic                     res_we0;
  logic signed [DATA_W-1:0] res_d0;

  modport master (
    output ap_start, ap_continue, in_V_dout, in_V_empty_n,
    input  ap_done, ap_idle, ap_ready, in_V_read,
           res_address0, res_ce0, res_we0, res_d0
  );

  modport slave (
    input  ap_start, ap_continue, in_V_dout, in_V_empty_n,
    output ap_done, ap_idle, ap_ready, in_V_read,
           res_address0, res_ce0, res_we0, res_d0
  );

endinterface

// File: rtl/sort_order_check.sv
// Sticky ordering monitor: flags any accepted word that is smaller than the
// word accepted before it within the same invocation.
module sort_order_check #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_accept,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_err
);

  logic signed [DATA_W-1:0] r_prev;
  logic                     r_first;
  logic                     r_err;

  // The first word of an invocation has no predecessor to compare against.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_err   <= 1'b0;
      r_first <= 1'b1;
    end else if (i_accept) begin
      r_first <= 1'b0;
      if (!r_first && (i_data < r_prev)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else if (i_accept) begin
      r_prev <= i_data;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/sort_collect.sv
// Terminal stage of the sort chain: drains N words from the last cell into result RAM
// addresses 0..N-1. Define SORT_COLLECT_CHECK_EN to add the sort_err ordering monitor.
module sort_collect
  import sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int N      = 8,
  parameter int ADDR_W = 3
) (
  input  logic ap_clk,
  input  logic ap_rst,
`ifdef SORT_COLLECT_CHECK_EN
  output logic sort_err,
`endif
  sort_collect_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(N-1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t          r_state;
  state_t          w_nextState;
  logic [ADDR_W:0] r_cnt;
  logic            r_doneReg;
  logic            w_startRun;
  logic            w_accept;
  logic            w_last;

  assign w_startRun = (r_state == ST_IDLE) && bus.ap_start;
  assign w_accept   = (r_state == ST_RUN) && bus.in_V_empty_n;
  assign w_last     = w_accept && (r_cnt == CNT_LAST);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A continue already present on the final accept skips DONE entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (bus.ap_start)     w_nextState = ST_RUN;
      ST_RUN:  if (w_last)           w_nextState = bus.ap_continue ? ST_IDLE : ST_DONE;
      ST_DONE: if (bus.ap_continue)  w_nextState = ST_IDLE;
      default:                       w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_cnt     <= '0;
      r_doneReg <= 1'b0;
    end else begin
      if (w_startRun) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      if (w_last && !bus.ap_continue) begin
        r_doneReg <= 1'b1;
      end else if ((r_state == ST_DONE) && bus.ap_continue) begin
        r_doneReg <= 1'b0;
      end
    end
  end

  // Stream word goes straight to RAM in the cycle it is accepted.
  always_comb begin
    bus.ap_idle      = 1'b0;
    bus.ap_ready     = 1'b0;
    bus.ap_done      = r_doneReg;
    bus.in_V_read    = 1'b0;
    bus.res_ce0      = 1'b0;
    bus.res_we0      = 1'b0;
    bus.res_address0 = '0;
    bus.res_d0       = '0;
    case (r_state)
      ST_IDLE: bus.ap_idle = !bus.ap_start;
      ST_RUN: begin
        if (w_accept) begin
          bus.in_V_read    = 1'b1;
          bus.res_ce0      = 1'b1;
          bus.res_we0      = 1'b1;
          bus.res_address0 = r_cnt[ADDR_W-1:0];
          bus.res_d0       = bus.in_V_dout;
        end
        if (w_last) begin
          bus.ap_done  = 1'b1;
          bus.ap_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef SORT_COLLECT_CHECK_EN
  sort_order_check #(
    .DATA_W(DATA_W)
  ) u_orderCheck (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .i_clear (w_startRun),
    .i_accept(w_accept),
    .i_data  (bus.in_V_dout),
    .o_err   (sort_err)
  );
`endif

endmodule

// File: tb/tb_sort_collect.sv
// Bench for sort_collect: vector table on an N=8 instance with a write scoreboard,
// plus a hand-run N=1 instance. Define SORT_COLLECT_CHECK_EN to also check sort_err.
module tb_sort_collect;
  import sort_pkg::*;

  typedef struct {
    logic rst;
    logic start;
    logic cont;
    logic vld;
    int   dat;
    logic expRead;
    int   expAddr;
    logic expDone;
    logic expReady;
    logic expIdle;
    logic expErr;
  } vec_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];
  wr_t  sb[$];

  always #5 clk = ~clk;

  sort_collect_if #(.DATA_W(32), .ADDR_W(3)) bus8 ();
  sort_collect_if #(.DATA_W(32), .ADDR_W(1)) bus1 ();

`ifdef SORT_COLLECT_CHECK_EN
  logic sortErr8;
  logic sortErr1;
  int   errData[8] = '{-3, 0, 0, 7, 2, 4, 5, 6};
`endif

  sort_collect #(.DATA_W(32), .N(8), .ADDR_W(3)) dut8 (
    .ap_clk  (clk),
    .ap_rst  (rst),
`ifdef SORT_COLLECT_CHECK_EN
    .sort_err(sortErr8),
`endif
    .bus     (bus8)
  );

  sort_collect #(.DATA_W(32), .N(1), .ADDR_W(1)) dut1 (
    .ap_clk  (clk),
    .ap_rst  (rst),
`ifdef SORT_COLLECT_CHECK_EN
    .sort_err(sortErr1),
`endif
    .bus     (bus1)
  );

  function automatic vec_t mk(input logic r, input logic s, input logic c, input logic v,
                              input int d, input logic eRd, input int eAddr,
                              input logic eDone, input logic eReady, input logic eIdle);
    vec_t x;
    x.rst = r; x.start = s; x.cont = c; x.vld = v; x.dat = d;
    x.expRead = eRd; x.expAddr = eAddr; x.expDone = eDone;
    x.expReady = eReady; x.expIdle = eIdle; x.expErr = 1'b0;
    return x;
  endfunction

  task automatic checkVal(input string name, input logic signed [31:0] actual,
                          input logic signed [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive just after the rising edge; an expected write is queued as it is driven.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst               = v.rst;
    bus8.ap_start     = v.start;
    bus8.ap_continue  = v.cont;
    bus8.in_V_empty_n = v.vld;
    bus8.in_V_dout    = v.dat;
    if (v.expRead) sb.push_back('{v.expAddr, v.dat});
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    wr_t w;
    @(negedge clk);
    checkVal($sformatf("v%0d read", idx), bus8.in_V_read, v.expRead);
    checkVal($sformatf("v%0d ce", idx), bus8.res_ce0, v.expRead);
    checkVal($sformatf("v%0d we", idx), bus8.res_we0, v.expRead);
    checkVal($sformatf("v%0d done", idx), bus8.ap_done, v.expDone);
    checkVal($sformatf("v%0d ready", idx), bus8.ap_ready, v.expReady);
    checkVal($sformatf("v%0d idle", idx), bus8.ap_idle, v.expIdle);
`ifdef SORT_COLLECT_CHECK_EN
    checkVal($sformatf("v%0d sort_err", idx), sortErr8, v.expErr);
`endif
    if (bus8.res_we0 === 1'b1) begin
      if (sb.size() == 0) begin
        checkVal($sformatf("v%0d unexpected write", idx), 1, 0);
      end else begin
        w = sb.pop_front();
        checkVal($sformatf("v%0d addr", idx), bus8.res_address0, w.addr);
        checkVal($sformatf("v%0d data", idx), bus8.res_d0, w.data);
      end
    end
  endtask

  initial begin
    vec_t v;
    rst               = 1'b1;
    bus8.ap_start     = 1'b0;
    bus8.ap_continue  = 1'b1;
    bus8.in_V_empty_n = 1'b0;
    bus8.in_V_dout    = '0;
    bus1.ap_start     = 1'b0;
    bus1.ap_continue  = 1'b1;
    bus1.in_V_empty_n = 1'b0;
    bus1.in_V_dout    = '0;

    // reset state
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    // back-to-back 1..8; data offered in the start cycle must not be read
    vecs.push_back(mk(0, 1, 1, 1, 99, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1, 1, i + 1, 1, i, i == 7, i == 7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    // empty_n pattern 1,0,0,1,...
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(0, 0, 1, 1, i + 1, 1, i, i == 7, i == 7, 0));
      if (i < 7) begin
        vecs.push_back(mk(0, 0, 1, 0, -1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, -1, 0, 0, 0, 0, 0));
      end
    end
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    // done hold with start and stream data present
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 1, i + 1, 1, i, i == 7, i == 7, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 1, 77, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    // reset after 3 accepts, then a fresh invocation from address 0
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 1, 1, 10 * (i + 1), 1, i, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 55, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1, 1, 100 + i, 1, i, i == 7, i == 7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

`ifdef SORT_COLLECT_CHECK_EN
    // out-of-order word 2 after 7, then an ascending restart clears the flag
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      v = mk(0, 0, 1, 1, errData[i], 1, i, i == 7, i == 7, 0);
      v.expErr = (i >= 5);
      vecs.push_back(v);
    end
    v = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    v.expErr = 1'b1;
    vecs.push_back(v);
    v = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v.expErr = 1'b1;
    vecs.push_back(v);
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1, 1, 2 * i - 4, 1, i, i == 7, i == 7, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end
    checkVal("scoreboard left", sb.size(), 0);

    // N=1 instance: the single word -5 completes the invocation
    @(posedge clk);
    #1;
    bus1.ap_start     = 1'b1;
    bus1.in_V_empty_n = 1'b1;
    bus1.in_V_dout    = -5;
    @(negedge clk);
    checkVal("n1 start read", bus1.in_V_read, 0);
    checkVal("n1 start idle", bus1.ap_idle, 0);
    @(posedge clk);
    #1;
    bus1.ap_start = 1'b0;
    @(negedge clk);
    checkVal("n1 we", bus1.res_we0, 1);
    checkVal("n1 addr", bus1.res_address0, 0);
    checkVal("n1 data", bus1.res_d0, -5);
    checkVal("n1 done", bus1.ap_done, 1);
    checkVal("n1 ready", bus1.ap_ready, 1);
    @(posedge clk);
    #1;
    bus1.in_V_empty_n = 1'b0;
    @(negedge clk);
    checkVal("n1 idle after", bus1.ap_idle, 1);
    checkVal("n1 done after", bus1.ap_done, 0);
    checkVal("n1 we after", bus1.res_we0, 0);
`ifdef SORT_COLLECT_CHECK_EN
    checkVal("n1 sort_err", sortErr1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_collect.md
Name: sort_collect

Overview:
- Terminal stage of the FIFO-coupled insertion-sort chain. Sits directly downstream of the last sort cell and drains that cell's output stream.
- Each invocation accepts exactly N signed words and writes them to consecutive addresses of an ap_memory-style result RAM port.
- Controlled with the chain handshake (ap_start/ap_done/ap_continue/ap_idle/ap_ready), so a top-level dataflow wrapper can sequence it alongside the cells.

Parameters:
- DATA_W, 32, width of stream words and RAM data (signed).
- N, 8, words collected per invocation; must be ≥1.
- ADDR_W, 3, RAM address width; must satisfy 2**ADDR_W ≥ N.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  start request.
- ap_done  out  1  invocation complete; held until ap_continue.
- ap_continue  in  1  acknowledges ap_done.
- ap_idle  out  1  block idle.
- ap_ready  out  1  ready for next ap_start (pulses with last accept).
- in_V_dout  in  DATA_W  stream data from the last cell.
- in_V_empty_n  in  1  stream data valid.
- in_V_read  out  1  stream pop.
- res_address0  out  ADDR_W  RAM write address.
- res_ce0  out  1  RAM chip enable.
- res_we0  out  1  RAM write enable.
- res_d0  out  DATA_W  RAM write data.

Behaviour:
- One-hot FSM, states IDLE, RUN, DONE. Registers: cnt[ADDR_W:0], ap_done_reg.
- Reset (ap_rst=1 at an edge): state=IDLE, cnt=0, ap_done_reg=0. This applies even mid-RUN; partially written RAM contents are left as-is.
- All outputs except ap_done are combinational and default to 0.

IDLE:
- ap_idle=1 when ap_start=0.
- ap_start=1 → RUN next cycle, cnt=0. No stream read occurs in the start cycle.

RUN:
- accept = in_V_empty_n.
- On accept, in the same cycle: in_V_read=1, res_ce0=1, res_we0=1, res_address0=cnt[ADDR_W-1:0], res_d0=in_V_dout. cnt increments at the edge.
- Zero latency from stream to RAM; throughput is 1 word/cycle.
- in_V_empty_n=0 → stall with all strobes 0 and cnt held. Stalls of unbounded length are legal.
- Accept with cnt==N-1:
  - ap_done=1 and ap_ready=1 combinationally in that cycle.
  - If ap_continue=0 in that cycle: ap_done_reg←1 and state←DONE.
  - If ap_continue=1 in that cycle: ap_done_reg stays 0 and state←IDLE.

DONE:
- ap_done=ap_done_reg=1. No reads, no writes; ap_start is ignored.
- ap_continue=1 → ap_done_reg←0, state←IDLE.

Other rules:
- ap_ready=1 only in the final-accept cycle.
- ap_idle=0 in RUN and DONE.
- Exactly N reads and N writes per invocation. Addresses run 0..N-1 ascending with no wrap.
- N=1: the first accepted word completes the invocation.
- Words on in_V arriving outside RUN are never popped.

Optional Feature:
- Macro SORT_COLLECT_CHECK_EN.
- Defined:
  - Adds output sort_err (1 bit), a register prev[DATA_W-1:0], and a first-word flag.
  - On every accept after the first in an invocation: if $signed(in_V_dout) < $signed(prev), sort_err←1.
  - prev is updated on every accept.
  - sort_err is sticky. It clears on ap_rst and on the ap_start edge from IDLE→RUN.
  - Equal consecutive values are legal.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sort_pkg:
  - DATA_W default.
  - FSM state encodings ST_IDLE=3'b001, ST_RUN=3'b010, ST_DONE=3'b100.
  - Typedef data_t = logic signed [DATA_W-1:0].
  - Shared with the cell stages.
- One natural sub-module, sort_order_check, holding the SORT_COLLECT_CHECK_EN logic (prev register, first flag, comparator, sticky flag). It is instantiated only under the macro.

Test Plan:
- N=8, ap_continue=1. Start, then feed 1,2,3,4,5,6,7,8 back-to-back. Required: 8 writes on consecutive cycles to addr 0..7 with d=1..8; ap_done=ap_ready=1 on the 8th accept cycle; ap_idle=1 the next cycle.
- Stalls: same data with in_V_empty_n toggling 1,0,0,1… Required: writes only on empty_n=1 cycles, addresses still contiguous 0..7, completion after the 8th valid word.
- Done hold: ap_continue=0 at completion. Required: ap_done stays 1 for 5 cycles; ap_start=1 and in_V_empty_n=1 during those cycles cause no read or write; ap_continue=1 → ap_idle=1 the next cycle.
- Reset mid-RUN: ap_rst=1 for one cycle after 3 accepts. Required: IDLE, all strobes 0; a fresh start writes from addr 0.
- N=1 (parameter override): single word -5. Required: one write, addr 0, d=-5, ap_done same cycle.
- With SORT_COLLECT_CHECK_EN: feed -3,0,0,7,2,… → sort_err rises after the 2 is accepted and stays 1. Restart with ascending data → sort_err clears at start and stays 0.
